jtag_master: RTL and testbench

- Host-side JTAG driver that generates TCK/TMS/TDI and samples TDO, to drive the team's DAP TAP from on-chip logic or a test harness.
- Runs one IR or DR scan per command: walks the TAP from Run-Test/Idle through Capture/Shift/Exit1/Update and back to Run-Test/Idle.
- Returns the bits captured from TDO.
- After reset it resets the TAP through Test-Logic-Reset.

---
 rtl/jtag_master.sv | 239 +++++++++++++++++++++++
 tb/tb_jtag_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG driver.
// Generates TCK/TMS/TDI and samples TDO. Runs one IR or DR scan per command,
// walking the TAP Run-Test/Idle -> Capture -> Shift -> Exit1 -> Update -> Run-Test/Idle.
// Out of reset it first walks the TAP through Test-Logic-Reset into Run-Test/Idle.
module jtag_master #(
    parameter int DIV     = 4,   // CLK cycles per TCK half-period (>= 1)
    parameter int MAX_LEN = 32   // maximum scan length in bits
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               is_ir,
    input  logic [5:0]         len,
    input  logic [MAX_LEN-1:0] data_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [MAX_LEN-1:0] data_out,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    localparam int            DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [6:0]    MAX_LEN_W = 7'(MAX_LEN);
    // Index of the last TCK cycle of the Test-Logic-Reset walk (6 cycles).
    localparam logic [5:0]    TLR_LAST  = 6'd5;

    typedef enum logic [2:0] {
        RESET_SEQ,
        IDLE,
        HDR,
        SHIFT,
        TRAIL,
        FINISH
    } state_t;

    state_t             state_reg, state_next;
    logic [DW-1:0]      div_cnt_reg, div_cnt_next;
    logic               tck_reg, tck_next;
    logic               tms_reg, tms_next;
    logic               tdi_reg, tdi_next;
    logic [5:0]         bit_cnt_reg, bit_cnt_next;
    logic               is_ir_reg, is_ir_next;
    logic [5:0]         len_reg, len_next;
    logic [MAX_LEN-1:0] data_reg, data_next;
    logic [MAX_LEN-1:0] mask_reg, mask_next;
    logic [MAX_LEN-1:0] cap_reg, cap_next;
    logic               err_reg, err_next;

    logic               active;
    logic               phase_end;
    logic               tck_rise;
    logic               tck_fall;
    logic               len_bad;
    logic [5:0]         len_last;
    logic [5:0]         hdr_last;

    // State and datapath registers; reset parks the pins in TLR-walk start condition.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= RESET_SEQ;
            div_cnt_reg <= '0;
            tck_reg     <= 1'b0;
            tms_reg     <= 1'b1;
            tdi_reg     <= 1'b0;
            bit_cnt_reg <= '0;
            is_ir_reg   <= 1'b0;
            len_reg     <= '0;
            data_reg    <= '0;
            mask_reg    <= '0;
            cap_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            tck_reg     <= tck_next;
            tms_reg     <= tms_next;
            tdi_reg     <= tdi_next;
            bit_cnt_reg <= bit_cnt_next;
            is_ir_reg   <= is_ir_next;
            len_reg     <= len_next;
            data_reg    <= data_next;
            mask_reg    <= mask_next;
            cap_reg     <= cap_next;
            err_reg     <= err_next;
        end
    end

    // Next-state logic: TCK phase timing, TMS/TDI sequencing and TDO capture.
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = '0;
        tck_next     = tck_reg;
        tms_next     = tms_reg;
        tdi_next     = tdi_reg;
        bit_cnt_next = bit_cnt_reg;
        is_ir_next   = is_ir_reg;
        len_next     = len_reg;
        data_next    = data_reg;
        mask_next    = mask_reg;
        cap_next     = cap_reg;
        err_next     = err_reg;

        active    = (state_reg == RESET_SEQ) || (state_reg == HDR) ||
                    (state_reg == SHIFT)     || (state_reg == TRAIL);
        phase_end = (div_cnt_reg == DIV_LAST);
        // A TCK cycle is DIV CLKs low then DIV CLKs high. The edge that ends the
        // high phase is also the edge that starts the next low phase, so TMS/TDI
        // for the following TCK cycle are loaded on tck_fall.
        tck_rise  = active && phase_end && !tck_reg;
        tck_fall  = active && phase_end && tck_reg;
        len_bad   = (len == 6'd0) || ({1'b0, len} > MAX_LEN_W);
        len_last  = len_reg - 6'd1;
        hdr_last  = is_ir_reg ? 6'd3 : 6'd2;

        if (active) begin
            div_cnt_next = phase_end ? '0 : div_cnt_reg + DW'(1);
        end
        if (tck_rise) begin
            tck_next = 1'b1;
        end
        if (tck_fall) begin
            tck_next = 1'b0;
        end

        // TDO is only meaningful while in Shift-xR; everything else is dropped.
        if (tck_rise && (state_reg == SHIFT)) begin
            cap_next = cap_reg | (TDO ? mask_reg : '0);
        end

        case (state_reg)
            RESET_SEQ: begin
                if (tck_fall) begin
                    if (bit_cnt_reg == TLR_LAST) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                        tms_next     = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                        // Five TMS=1 cycles reach TLR, the sixth (TMS=0) enters RTI.
                        tms_next     = ((bit_cnt_reg + 6'd1) != TLR_LAST);
                    end
                end
            end

            IDLE: begin
                tms_next = 1'b0;
                tdi_next = 1'b0;
                if (start) begin
                    if (len_bad) begin
                        // Rejected: no TCK activity and data_out is left alone.
                        state_next = FINISH;
                        err_next   = 1'b1;
                    end else begin
                        state_next   = HDR;
                        is_ir_next   = is_ir;
                        len_next     = len;
                        data_next    = data_in;
                        mask_next    = MAX_LEN'(1);
                        cap_next     = '0;
                        bit_cnt_next = '0;
                        tms_next     = 1'b1;   // RTI -> Select-DR-Scan
                        tdi_next     = 1'b0;
                    end
                end
            end

            HDR: begin
                if (tck_fall) begin
                    if (bit_cnt_reg == hdr_last) begin
                        // Now in Shift-xR: present bit 0; a 1-bit scan exits at once.
                        state_next   = SHIFT;
                        bit_cnt_next = '0;
                        tdi_next     = data_reg[0];
                        tms_next     = (len_reg == 6'd1);
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                        // IR scans need a second TMS=1 (Select-DR -> Select-IR).
                        tms_next     = is_ir_reg && (bit_cnt_reg == 6'd0);
                    end
                end
            end

            SHIFT: begin
                if (tck_fall) begin
                    if (bit_cnt_reg == len_last) begin
                        state_next   = TRAIL;
                        bit_cnt_next = '0;
                        tms_next     = 1'b1;   // Exit1 -> Update
                        tdi_next     = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                        mask_next    = mask_reg << 1;
                        tdi_next     = |(data_reg & (mask_reg << 1));
                        // The final shift cycle carries TMS=1 to leave via Exit1.
                        tms_next     = ((bit_cnt_reg + 6'd1) == len_last);
                    end
                end
            end

            TRAIL: begin
                if (tck_fall) begin
                    tms_next = 1'b0;           // Update -> RTI, then stay in RTI
                    if (bit_cnt_reg == 6'd1) begin
                        state_next   = FINISH;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = 6'd1;
                    end
                end
            end

            FINISH: begin
                // One-CLK completion slot; start is ignored here.
                state_next = IDLE;
                err_next   = 1'b0;
            end

            default: begin
                state_next = RESET_SEQ;
            end
        endcase
    end

    // Status outputs decode directly from the state so done/busy switch together.
    always_comb begin
        busy     = (state_reg != IDLE) && (state_reg != FINISH);
        done     = (state_reg == FINISH);
        err      = (state_reg == FINISH) && err_reg;
        data_out = cap_reg;
        TCK      = tck_reg;
        TMS      = tms_reg;
        TDI      = tdi_reg;
    end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: randomized self-checking bench for jtag_master.
// A behavioural target drives TDO (random pattern or one-TCK loopback) and a
// monitor logs TMS/TDI on every TCK rise; expectations come from TAP-walk rules.
module tb_jtag_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        is_ir = 1'b0;
    logic [5:0]  len = 6'd0;
    logic [31:0] data_in = 32'd0;
    logic        TDO = 1'b0;
    logic        busy, done, err, TCK, TMS, TDI;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;

    // TCK-level log and target model state
    logic [63:0] tms_log = '0;
    logic [63:0] tdi_log = '0;
    logic [63:0] tdo_pat = '0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          done_cnt = 0;
    int          tdo_mode = 0;      // 0 = pattern, 1 = loopback (bypass-like)
    logic        prev_tck = 1'b0;
    logic        last_tdi = 1'b0;

    jtag_master #(.DIV(4), .MAX_LEN(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .is_ir    (is_ir),
        .len      (len),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .data_out (data_out),
        .TCK      (TCK),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor and target: sample just after each CLK edge, log TCK rises, and
    // present the next TDO bit after every TCK fall.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (done) done_cnt++;
            if (TCK && !prev_tck) begin
                if (rise_cnt < 64) begin
                    tms_log[rise_cnt] = TMS;
                    tdi_log[rise_cnt] = TDI;
                end
                last_tdi = TDI;
                rise_cnt++;
            end else if (!TCK && prev_tck) begin
                fall_cnt++;
                if (tdo_mode == 1) TDO = last_tdi;
                else TDO = (fall_cnt < 64) ? tdo_pat[fall_cnt] : 1'b0;
            end
            prev_tck = TCK;
        end
    end

    task automatic clear_log();
        rise_cnt = 0;
        fall_cnt = 0;
        done_cnt = 0;
        tms_log  = '0;
        tdi_log  = '0;
    endtask

    function automatic logic [63:0] len_mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // Expected TMS per TCK cycle: Select-DR (+Select-IR), Capture, Shift...,
    // shift bits with Exit1 on the last, then Update and Run-Test/Idle.
    function automatic logic [63:0] exp_tms(input logic ir, input int n);
        logic [63:0] v;
        int h;
        v = '0;
        h = ir ? 4 : 3;
        v[0] = 1'b1;
        if (ir) v[1] = 1'b1;
        v[h + n - 1] = 1'b1;
        v[h + n]     = 1'b1;
        return v;
    endfunction

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while ((busy || done) && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 3000) check_val({tag, "_idle_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while (!done && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        check_val({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic do_scan(input logic ir, input int n, input logic [31:0] d,
                           input int mode, input string tag);
        int h;
        logic [63:0] exp_out;
        h = ir ? 4 : 3;
        if (mode == 1) exp_out = ({32'd0, d} << 1) & len_mask(n);
        else exp_out = (tdo_pat >> h) & len_mask(n);
        wait_idle(tag);
        @(negedge CLK);
        clear_log();
        tdo_mode = mode;
        TDO      = (mode == 1) ? 1'b0 : tdo_pat[0];
        is_ir    = ir;
        len      = 6'(n);
        data_in  = d;
        start    = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check_val({tag, "_busy_hi"}, {63'd0, busy}, 64'd1);
        // Competing command while busy must be dropped.
        is_ir   = ~ir;
        len     = 6'd3;
        data_in = ~d;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(tag);
        check_val({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_err"}, {63'd0, err}, 64'd0);
        check_val({tag, "_ntck"}, 64'(rise_cnt), 64'(n + h + 2));
        check_val({tag, "_tms"}, tms_log, exp_tms(ir, n));
        check_val({tag, "_tdi"}, tdi_log, ({32'd0, d} & len_mask(n)) << h);
        check_val({tag, "_dout"}, {32'd0, data_out}, exp_out);
        // A start coinciding with done is ignored.
        is_ir   = 1'b0;
        len     = 6'd8;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check_val({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_val({tag, "_start_on_done"}, {63'd0, busy}, 64'd0);
        $display("scan %s ir=%0d len=%0d din=0x%08h dout=0x%08h tck=%0d", tag, ir, n, d, data_out, rise_cnt);
    endtask

    task automatic check_tlr(input string tag);
        int guard;
        guard = 0;
        while (busy && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        check_val({tag, "_tlr_busy"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_tlr_ntck"}, 64'(rise_cnt), 64'd6);
        check_val({tag, "_tlr_tms"}, tms_log, 64'h1F);
        check_val({tag, "_tlr_nodone"}, 64'(done_cnt), 64'd0);
        check_val({tag, "_idle_tms"}, {63'd0, TMS}, 64'd0);
        $display("tlr %s tck=%0d tms=0x%0h", tag, rise_cnt, tms_log);
    endtask

    initial begin
        logic [31:0] prev_out;
        int guard;
        int n;
        logic ir;
        int mode;

        // Reset values and Test-Logic-Reset walk
        repeat (3) @(negedge CLK);
        check_val("rst_tck",  {63'd0, TCK},  64'd0);
        check_val("rst_tms",  {63'd0, TMS},  64'd1);
        check_val("rst_tdi",  {63'd0, TDI},  64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd1);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_err",  {63'd0, err},  64'd0);
        check_val("rst_dout", {32'd0, data_out}, 64'd0);
        clear_log();
        RST = 1'b0;
        check_tlr("por");

        // DAP IR capture: shift region returns all ones, other TDO bits random
        tdo_pat = {$urandom, $urandom};
        tdo_pat[4 +: 8] = 8'hFF;
        do_scan(1'b1, 8, 32'hFF, 0, "dap_ir");
        check_val("dap_ir_lit", {32'd0, data_out}, 64'hFF);

        // Bypass: one-bit delay with capture 0
        do_scan(1'b0, 8, 32'hA5, 1, "bypass");
        check_val("bypass_lit", {32'd0, data_out}, 64'h4A);

        // Full-width loopback
        do_scan(1'b0, 32, 32'hDEADBEEF, 1, "loop32");

        // Rejected lengths
        foreach (tdo_pat[i]) begin end
        for (int k = 0; k < 2; k++) begin
            wait_idle("reject");
            @(negedge CLK);
            prev_out = data_out;
            clear_log();
            len   = (k == 0) ? 6'd0 : 6'd40;
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            check_val("reject_done", {63'd0, done}, 64'd1);
            check_val("reject_err",  {63'd0, err},  64'd1);
            check_val("reject_dout", {32'd0, data_out}, {32'd0, prev_out});
            repeat (20) @(negedge CLK);
            check_val("reject_ntck", 64'(rise_cnt), 64'd0);
            check_val("reject_ndone", 64'(done_cnt), 64'd1);
            $display("reject len=%0d done=1 err=1 dout=0x%08h", len, data_out);
        end

        // Randomized scans, always including the 1-bit and MAX_LEN extremes
        for (int i = 0; i < 10; i++) begin
            ir   = 1'($urandom % 2);
            n    = (i == 0) ? 1 : (i == 1) ? 32 : int'($urandom_range(1, 32));
            mode = int'($urandom % 2);
            tdo_pat = {$urandom, $urandom};
            do_scan(ir, n, $urandom, mode, "rand");
        end

        // Reset in the middle of a 32-bit DR scan
        wait_idle("midrst");
        @(negedge CLK);
        clear_log();
        tdo_mode = 0;
        is_ir    = 1'b0;
        len      = 6'd32;
        data_in  = $urandom;
        start    = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        guard = 0;
        while (rise_cnt < 13 && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        check_val("midrst_reach", 64'(rise_cnt), 64'd13);
        RST = 1'b1;
        #1;
        check_val("midrst_tck",  {63'd0, TCK},  64'd0);
        check_val("midrst_tms",  {63'd0, TMS},  64'd1);
        check_val("midrst_busy", {63'd0, busy}, 64'd1);
        repeat (2) @(negedge CLK);
        clear_log();
        RST = 1'b0;
        check_tlr("midrst");
        tdo_pat = {$urandom, $urandom};
        do_scan(1'b1, 8, $urandom, 0, "post_rst_ir");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
